// File: rtl/data_memory_unit_pkg.sv
// ============================================================================
// data_memory_unit_pkg : shared funct3 encodings and FSM state type
// Revision: 1.0
// ============================================================================
`default_nettype none

package data_memory_unit_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/data_memory_unit_lane_align.sv
// ============================================================================
// mem_lane_align : store lane enables/shift, load extraction/extension,
//                  alignment and funct3 legality check (combinational)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
  import data_memory_unit_pkg::*;
(
  input  logic        i_is_store,
  input  logic [1:0]  i_lo,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_ram_word,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load,
  output logic        o_err
);

  logic [31:0] w_shift;
  logic        w_mis_h;
  logic        w_mis_w;

  assign w_shift = i_ram_word >> {i_lo, 3'b000};
  assign w_mis_h = i_lo[0];
  assign w_mis_w = |i_lo;

  always_comb begin
    o_byte_en = 4'b0000;
    o_wdata   = 32'h0;
    o_load    = 32'h0;
    o_err     = 1'b0;
    if (i_is_store) begin
      // Replicate the narrow datum so every lane carries it; byte_en picks one.
      case (i_funct3)
        MEM_B: begin
          o_byte_en = 4'b0001 << i_lo;
          o_wdata   = {4{i_store_data[7:0]}};
        end
        MEM_H: begin
          o_byte_en = i_lo[1] ? 4'b1100 : 4'b0011;
          o_wdata   = {2{i_store_data[15:0]}};
          o_err     = w_mis_h;
        end
        MEM_W: begin
          o_byte_en = 4'b1111;
          o_wdata   = i_store_data;
          o_err     = w_mis_w;
        end
        default: o_err = 1'b1;
      endcase
    end else begin
      case (i_funct3)
        MEM_B:  o_load = {{24{w_shift[7]}}, w_shift[7:0]};
        MEM_BU: o_load = {24'h0, w_shift[7:0]};
        MEM_H: begin
          o_load = {{16{w_shift[15]}}, w_shift[15:0]};
          o_err  = w_mis_h;
        end
        MEM_HU: begin
          o_load = {16'h0, w_shift[15:0]};
          o_err  = w_mis_h;
        end
        MEM_W: begin
          o_load = i_ram_word;
          o_err  = w_mis_w;
        end
        default: o_err = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_memory_unit.sv
// ============================================================================
// data_memory_unit : RV32I load/store responder with wait-stated word RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_memory_unit
  import data_memory_unit_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        access_error
);

  localparam int         c_AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_WAIT = 4'(WAIT_STATES);

  mem_state_t      r_state;
  mem_state_t      w_next;
  logic [c_AW-1:0] r_idx;
  logic [1:0]      r_lo;
  logic [2:0]      r_f3;
  logic [31:0]     r_wd;
  logic            r_store;
  logic [3:0]      r_cnt;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic        w_req;
  logic        w_idle;
  logic        w_start;
  logic        w_fire;
  logic        w_al_store;
  logic [1:0]  w_al_lo;
  logic [2:0]  w_al_f3;
  logic [31:0] w_al_wd;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load;
  logic        w_err;
  logic        w_unused_addr;

  assign w_req         = read_enable | write_enable;
  assign w_idle        = (r_state == MEM_IDLE);
  assign w_fire        = (r_state == MEM_ACCESS) && (r_cnt == 4'd0);
  assign w_unused_addr = &{1'b0, address[31:c_AW+2]};

  // Live operands are checked in IDLE; latched operands drive the access.
  assign w_al_store = w_idle ? write_enable     : r_store;
  assign w_al_lo    = w_idle ? address[1:0]     : r_lo;
  assign w_al_f3    = w_idle ? funct3           : r_f3;
  assign w_al_wd    = w_idle ? write_data       : r_wd;

  mem_lane_align u_align (
    .i_is_store   (w_al_store),
    .i_lo         (w_al_lo),
    .i_funct3     (w_al_f3),
    .i_store_data (w_al_wd),
    .i_ram_word   (r_mem[r_idx]),
    .o_byte_en    (w_be),
    .o_wdata      (w_wdata),
    .o_load       (w_load),
    .o_err        (w_err)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= MEM_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    busy         = 1'b0;
    access_error = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        if (w_req) begin
          if (w_err) begin
            access_error = 1'b1;
          end else begin
            busy    = 1'b1;
            w_start = 1'b1;
            w_next  = MEM_ACCESS;
          end
        end
      end
      MEM_ACCESS: begin
        busy = 1'b1;
        if (r_cnt == 4'd0) w_next = MEM_DONE;
      end
      MEM_DONE: w_next = MEM_IDLE;
      default:  w_next = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_lo      <= 2'b00;
      r_f3      <= 3'b000;
      r_wd      <= 32'h0;
      r_store   <= 1'b0;
      r_cnt     <= 4'd0;
      read_data <= 32'h0;
    end else begin
      if (w_start) begin
        r_idx   <= address[c_AW+1:2];
        r_lo    <= address[1:0];
        r_f3    <= funct3;
        r_wd    <= write_data;
        r_store <= write_enable;
        r_cnt   <= c_WAIT;
      end else if ((r_state == MEM_ACCESS) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_fire && !r_store) read_data <= w_load;
    end
  end

  // RAM is not cleared by reset; a store aborted by reset never commits.
  always_ff @(posedge clk) begin
    if (!reset && w_fire && r_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_unit.sv
// ============================================================================
// tb_data_memory_unit : scoreboard bench for data_memory_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_memory_unit;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_a, re_a, we_a, busy_a, err_a;
  logic [31:0] addr_a, wd_a, rd_a;
  logic [2:0]  f3_a;
  logic        rst_b, re_b, we_b, busy_b, err_b;
  logic [31:0] addr_b, wd_b, rd_b;
  logic [2:0]  f3_b;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] last_rd = 32'h0;
  logic        prev_busy = 1'b0;

  always #5 clk = ~clk;

  data_memory_unit #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_dut_a (
    .clk(clk), .reset(rst_a), .read_enable(re_a), .write_enable(we_a),
    .address(addr_a), .funct3(f3_a), .write_data(wd_a),
    .read_data(rd_a), .busy(busy_a), .access_error(err_a));

  data_memory_unit #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut_b (
    .clk(clk), .reset(rst_b), .read_enable(re_b), .write_enable(we_b),
    .address(addr_b), .funct3(f3_b), .write_data(wd_b),
    .read_data(rd_b), .busy(busy_b), .access_error(err_b));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Completion monitor: busy falling marks DONE, where read_data is valid.
  always @(negedge clk) begin
    if (!rst_a && prev_busy && !busy_a) begin
      if (exp_q.size() == 0) begin
        check("unexpected completion", 32'h1, 32'h0);
      end else begin
        check(name_q.pop_front(), rd_a, exp_q.pop_front());
      end
    end
    prev_busy = busy_a;
  end

  // re/we, address, funct3, data; exp is read_data expected in DONE.
  task automatic op_a(input logic re, input logic we, input logic [31:0] a,
                      input logic [2:0] f, input logic [31:0] d, input string nm);
    logic [31:0] exp;
    int n;
    exp = (we || !re) ? last_rd : 32'h0;
    if (!we) exp = model_load(a, f);
    last_rd = exp;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk); #1;
    re_a = re; we_a = we; addr_a = a; f3_a = f; wd_a = d;
    n = 0;
    @(negedge clk);
    while (busy_a && n < 50) begin
      n++;
      @(negedge clk);
    end
    re_a = 1'b0; we_a = 1'b0;
    check({nm, " busy cycles"}, 32'(n), 32'd3);
  endtask

  task automatic err_a_op(input logic re, input logic we, input logic [31:0] a,
                          input logic [2:0] f, input string nm);
    @(posedge clk); #1;
    re_a = re; we_a = we; addr_a = a; f3_a = f; wd_a = 32'hCAFEF00D;
    @(negedge clk);
    check({nm, " error pulse"}, {31'h0, err_a}, 32'd1);
    check({nm, " busy low"}, {31'h0, busy_a}, 32'd0);
    @(posedge clk); #1;
    re_a = 1'b0; we_a = 1'b0;
    @(negedge clk);
    check({nm, " error cleared"}, {31'h0, err_a | busy_a}, 32'd0);
    check({nm, " read_data held"}, rd_a, last_rd);
  endtask

  task automatic op_b(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input string nm);
    int n;
    @(posedge clk); #1;
    re_b = !we; we_b = we; addr_b = a; f3_b = 3'b010; wd_b = d;
    n = 0;
    @(negedge clk);
    while (busy_b && n < 50) begin
      n++;
      @(negedge clk);
    end
    re_b = 1'b0; we_b = 1'b0;
    check({nm, " busy cycles"}, 32'(n), 32'd5);
    check({nm, " data"}, rd_b, exp);
  endtask

  // Hand-computed memory image for DUT A (only the words this bench touches).
  logic [31:0] img [logic [31:0]];

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
    logic [31:0] w;
    logic [31:0] s;
    w = img.exists({a[11:2], 2'b00}) ? img[{a[11:2], 2'b00}] : 32'h0;
    s = w >> (8 * a[1:0]);
    case (f)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  initial begin
    rst_a = 1'b1; re_a = 1'b0; we_a = 1'b0; addr_a = 32'h0; f3_a = 3'b0; wd_a = 32'h0;
    rst_b = 1'b1; re_b = 1'b0; we_b = 1'b0; addr_b = 32'h0; f3_b = 3'b0; wd_b = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset read_data", rd_a, 32'h0);
    check("reset busy", {31'h0, busy_a}, 32'd0);
    check("reset access_error", {31'h0, err_a}, 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    img[32'h100] = 32'h8081F2F3;
    op_a(1'b0, 1'b1, 32'h100, 3'b010, 32'h8081F2F3, "SW 0x100");
    op_a(1'b1, 1'b0, 32'h100, 3'b010, 32'h0, "LW 0x100");
    check("LW model", last_rd, 32'h8081F2F3);
    op_a(1'b1, 1'b0, 32'h101, 3'b000, 32'h0, "LB 0x101");
    check("LB model", last_rd, 32'hFFFFFFF2);
    op_a(1'b1, 1'b0, 32'h103, 3'b100, 32'h0, "LBU 0x103");
    check("LBU model", last_rd, 32'h00000080);
    op_a(1'b1, 1'b0, 32'h102, 3'b001, 32'h0, "LH 0x102");
    check("LH model", last_rd, 32'hFFFF8081);
    op_a(1'b1, 1'b0, 32'h100, 3'b101, 32'h0, "LHU 0x100");
    check("LHU model", last_rd, 32'h0000F2F3);

    img[32'h100] = 32'h80AAF2F3;
    op_a(1'b0, 1'b1, 32'h102, 3'b000, 32'h123456AA, "SB 0x102");
    op_a(1'b1, 1'b0, 32'h100, 3'b010, 32'h0, "LW after SB");
    img[32'h100] = 32'h80AA1234;
    op_a(1'b0, 1'b1, 32'h100, 3'b001, 32'hFFFF1234, "SH 0x100");
    op_a(1'b1, 1'b0, 32'h100, 3'b010, 32'h0, "LW after SH");
    check("SH model", last_rd, 32'h80AA1234);

    err_a_op(1'b1, 1'b0, 32'h101, 3'b010, "LW misaligned");
    err_a_op(1'b0, 1'b1, 32'h103, 3'b001, "SH misaligned");
    err_a_op(1'b1, 1'b0, 32'h100, 3'b011, "load funct3 011");
    err_a_op(1'b0, 1'b1, 32'h100, 3'b100, "store funct3 100");
    op_a(1'b1, 1'b0, 32'h100, 3'b010, 32'h0, "LW after errors");

    op_a(1'b1, 1'b0, 32'h100 + 4 * DEPTH, 3'b010, 32'h0, "LW wrap");
    img[32'h104] = 32'h55667788;
    op_a(1'b1, 1'b1, 32'h104, 3'b010, 32'h55667788, "RE+WE store");
    op_a(1'b1, 1'b0, 32'h104, 3'b010, 32'h0, "LW 0x104");

    // DUT B: reset during the second ACCESS cycle drops the pending store.
    op_b(1'b1, 32'h200, 32'h11223344, 32'h0, "B SW old");
    op_b(1'b0, 32'h200, 32'h0, 32'h11223344, "B LW old");
    @(posedge clk); #1;
    re_b = 1'b0; we_b = 1'b1; addr_b = 32'h200; f3_b = 3'b010; wd_b = 32'hDEADBEEF;
    @(posedge clk);
    @(posedge clk); #1;
    rst_b = 1'b1; we_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(negedge clk);
    check("B abort busy", {31'h0, busy_b}, 32'd0);
    check("B abort read_data", rd_b, 32'h0);
    op_b(1'b0, 32'h200, 32'h0, 32'h11223344, "B LW after abort");

    repeat (3) @(posedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
- Responder side of the load/store control interface. Consumes the data-memory read/write enables, the ALU-computed address, funct3 and rs2 data.
- Performs RV32I byte, half and word loads and stores against a word-organised synchronous RAM with configurable wait states.
- Asserts busy so the control path holds the PC and register write until the access completes.
- Sits beside the ALU in the single-cycle core, feeding the DATA writeback path.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two.
WAIT_STATES, 1, extra stall cycles per access; range 0..15.

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
read_enable  in  1  load request (data_mem_read_enable)
write_enable  in  1  store request (data_mem_write_enable)
address  in  32  byte address from ALU
funct3  in  3  access size/sign from instruction
write_data  in  32  store data (rs2)
read_data  out  32  extended load result, registered
busy  out  1  stall request; hold PC and regfile write while high
access_error  out  1  one-cycle pulse: misaligned address or illegal funct3

Behaviour:
- Reset: state IDLE; read_data=0; busy=0; access_error=0; wait counter=0. RAM contents are not cleared.
- Request = read_enable | write_enable. Both high at once: treat as store; read_data is unchanged.
- Word index = address[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so accesses wrap modulo memory size.
- Legal loads: 000 LB (sign-extend), 001 LH (sign-extend), 010 LW, 100 LBU (zero-extend), 101 LHU (zero-extend).
- Legal stores: 000 SB, 001 SH, 010 SW. Byte lanes are little-endian.
- Stores write only the addressed lanes; SB/SH take the low byte/half of write_data.
- Error: funct3 illegal for the access type, or misaligned (half with address[0]=1, word with address[1:0]!=0).
  - In IDLE: access_error=1 combinationally for that cycle, busy=0, no RAM change, read_data unchanged, state stays IDLE.
- FSM: IDLE -> ACCESS -> DONE -> IDLE.
  - IDLE, valid request: busy=1 combinationally in the request cycle. Latch address, funct3, write_data and type. Counter=WAIT_STATES. Go to ACCESS.
  - ACCESS: busy=1. Counter decrements each cycle. At counter==0 the access executes on the clock edge into DONE: the store commits to RAM, or the load result is extended and registered into read_data.
  - DONE: busy=0 and read_data valid, so the core retires the instruction this cycle. The enables still high in DONE belong to the same instruction and are ignored. Unconditional return to IDLE.
- Latency: request seen in IDLE at cycle t. busy is high for cycles t..t+WAIT_STATES+1. DONE falls at cycle t+WAIT_STATES+2.
  - WAIT_STATES=0 gives one ACCESS cycle, so busy is high for 2 cycles.
- Latched operands are used throughout ACCESS; input changes during ACCESS are ignored.
- Reset mid-ACCESS: abort to IDLE. A store not yet committed is dropped; read_data goes to 0.
- No request in IDLE: busy=0; read_data holds its last value.

Decomposition:
- Shared constants file: funct3 load/store encodings (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU) and the FSM state enum (MEM_IDLE, MEM_ACCESS, MEM_DONE).
- One natural combinational sub-module, mem_lane_align, containing:
  - store byte-enable/data-shift generation;
  - load lane select plus sign/zero extension;
  - alignment and illegal-funct3 checking.
- Top level holds the FSM, wait counter, operand latches and RAM array.

Test Plan:
- SW 0x8081F2F3 to 0x100, WAIT_STATES=1 -> busy high 3 cycles; then LW 0x100 -> read_data=0x8081F2F3 in DONE, busy=0.
- With that word present: LB 0x101 -> 0xFFFFFFF2; LBU 0x103 -> 0x00000080; LH 0x102 -> 0xFFFF8081; LHU 0x100 -> 0x0000F2F3.
- SB 0xAA to 0x102, then LW 0x100 -> 0x80AAF2F3 (other lanes untouched); SH 0x1234 to 0x100 -> LW gives 0x80AA1234.
- LW 0x101, SH 0x103, LH funct3=011 -> access_error pulses 1 cycle, busy never rises, RAM and read_data unchanged.
- Start SW 0xDEADBEEF to 0x200 with WAIT_STATES=3, assert reset in the 2nd ACCESS cycle -> FSM in IDLE, busy=0, read_data=0; subsequent LW 0x200 returns the old contents.
- LW to address 0x100 + 4*DEPTH_WORDS -> same data as 0x100 (wrap); read_enable and write_enable together -> store performed, read_data unchanged.
